// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control blocks.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    IMEM_WAIT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch squash with an
// optional extended flush window, IMEM wait states, perf counters, fetch timeout.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int EXTRA_FLUSH = 0,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  branch_taken_i,
  input  logic                  imem_ready_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic                  err_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic pc_w, ifid_w, ifid_f, idex_b;
  logic lu_hazard;

  assign lu_hazard = ex_memread_i && (ex_rd_i != '0) &&
                     ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_b  = 1'b0;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (branch_taken_i) begin
      ifid_w = 1'b0;
      ifid_f = 1'b1;
      idex_b = 1'b1;
      if (EXTRA_FLUSH > 0) begin
        state_d = FLUSH;
        fcnt_d  = 3'(EXTRA_FLUSH);
      end else begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    end else if (state_q == FLUSH) begin
      // Fetched data is discarded here, so imem_ready_i is deliberately ignored.
      ifid_w = 1'b0;
      ifid_f = 1'b1;
      if (fcnt_q <= 3'd1) begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end else if (lu_hazard) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_b  = 1'b1;
      state_d = imem_ready_i ? RUN : IMEM_WAIT;
    end else if (!imem_ready_i) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      ifid_f  = 1'b1;
      state_d = IMEM_WAIT;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != IMEM_WAIT) begin
      wait_d = '0;
    end else if ((state_q == IMEM_WAIT) && !imem_ready_i && (wait_q != WAIT_W'(TIMEOUT))) begin
      wait_d = wait_q + 1'b1;
    end
    err_d = err_q || (wait_d == WAIT_W'(TIMEOUT));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~pc_w),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (branch_taken_i),
    .cnt_o (flush_cnt_o)
  );

  assign pc_write_o    = rst_i & pc_w;
  assign ifid_write_o  = rst_i & ifid_w;
  assign ifid_flush_o  = rst_i & ifid_f;
  assign idex_bubble_o = rst_i & idex_b;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with a flush window and short
// timeout, one with no flush window and narrow counters.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses_rs2, memread, branch, ready;

  logic        pc_a, ifw_a, fl_a, bub_a, err_a;
  logic [15:0] stall_a, flcnt_a;
  logic        pc_b, ifw_b, fl_b, bub_b, err_b;
  logic [2:0]  stall_b, flcnt_b;
  logic [3:0]  ctl_a, ctl_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  assign ctl_a = {pc_a, ifw_a, bub_a, fl_a};
  assign ctl_b = {pc_b, ifw_b, bub_b, fl_b};

  hazard_ctrl #(.EXTRA_FLUSH(2), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs2_i(uses_rs2), .ex_rd_i(ex_rd), .ex_memread_i(memread),
    .branch_taken_i(branch), .imem_ready_i(ready), .pc_write_o(pc_a),
    .ifid_write_o(ifw_a), .ifid_flush_o(fl_a), .idex_bubble_o(bub_a),
    .stall_cnt_o(stall_a), .flush_cnt_o(flcnt_a), .err_o(err_a));

  hazard_ctrl #(.EXTRA_FLUSH(0), .TIMEOUT(64), .CNT_W(3)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs2_i(uses_rs2), .ex_rd_i(ex_rd), .ex_memread_i(memread),
    .branch_taken_i(branch), .imem_ready_i(ready), .pc_write_o(pc_b),
    .ifid_write_o(ifw_b), .ifid_flush_o(fl_b), .idex_bubble_o(bub_b),
    .stall_cnt_o(stall_b), .flush_cnt_o(flcnt_b), .err_o(err_b));

  task automatic idle();
    branch = 0; memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; uses_rs2 = 0; ready = 1;
  endtask

  // Ends on a falling edge with reset released; the next rising edge is active.
  task automatic do_reset();
    @(negedge clk_i);
    idle();
    rst_i = 0;
    @(negedge clk_i);
    rst_i = 1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 0; idle(); ready = 0; branch = 1;
    #1;
    n_vec++; if (ctl_a !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b expected 0000", ctl_a); end
    @(negedge clk_i); #1;
    n_vec++; if (stall_a !== 16'd0 || flcnt_a !== 16'd0 || err_a !== 1'b0) begin
      n_err++; $display("FAIL reset_state: stall=%0d flush=%0d err=%b expected 0 0 0", stall_a, flcnt_a, err_a); end
    idle();
    rst_i = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    memread = 1; ex_rd = 5; id_rs1 = 5; #1;
    n_vec++; if (ctl_a !== 4'b0010) begin n_err++; $display("FAIL lu_rs1_ctl: got %b expected 0010", ctl_a); end
    @(negedge clk_i); idle(); #1;
    n_vec++; if (stall_a !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_a); end
    n_vec++; if (ctl_a !== 4'b1100) begin n_err++; $display("FAIL lu_release: got %b expected 1100", ctl_a); end
    memread = 1; ex_rd = 7; id_rs1 = 3; id_rs2 = 7; uses_rs2 = 1; #1;
    n_vec++; if (ctl_a !== 4'b0010) begin n_err++; $display("FAIL lu_rs2_ctl: got %b expected 0010", ctl_a); end
    uses_rs2 = 0; #1;
    n_vec++; if (ctl_a !== 4'b1100) begin n_err++; $display("FAIL lu_rs2_unused: got %b expected 1100", ctl_a); end
    @(negedge clk_i); idle(); #1;
    n_vec++; if (stall_a !== 16'd1) begin n_err++; $display("FAIL lu_no_extra_stall: got %0d expected 1", stall_a); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    memread = 1; ex_rd = 0; id_rs1 = 0; #1;
    n_vec++; if (ctl_a !== 4'b1100) begin n_err++; $display("FAIL rd0_ctl: got %b expected 1100", ctl_a); end
    @(negedge clk_i); idle(); #1;
    n_vec++; if (stall_a !== 16'd0) begin n_err++; $display("FAIL rd0_stall_cnt: got %0d expected 0", stall_a); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    branch = 1; #1;
    n_vec++; if (ctl_a !== 4'b1011) begin n_err++; $display("FAIL br_cycle_a: got %b expected 1011", ctl_a); end
    n_vec++; if (ctl_b !== 4'b1011) begin n_err++; $display("FAIL br_cycle_b: got %b expected 1011", ctl_b); end
    @(negedge clk_i); branch = 0; #1;
    n_vec++; if (ctl_a !== 4'b1001) begin n_err++; $display("FAIL br_flush1: got %b expected 1001", ctl_a); end
    n_vec++; if (ctl_b !== 4'b1100) begin n_err++; $display("FAIL br_noflush_b: got %b expected 1100", ctl_b); end
    n_vec++; if (flcnt_a !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt: got %0d expected 1", flcnt_a); end
    @(negedge clk_i); #1;
    n_vec++; if (ctl_a !== 4'b1001) begin n_err++; $display("FAIL br_flush2: got %b expected 1001", ctl_a); end
    @(negedge clk_i); #1;
    n_vec++; if (ctl_a !== 4'b1100) begin n_err++; $display("FAIL br_back_run: got %b expected 1100", ctl_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    branch = 1;
    @(negedge clk_i); branch = 0; ready = 0; #1;
    n_vec++; if (ctl_a !== 4'b1001) begin n_err++; $display("FAIL b2b_flush_ignores_imem: got %b expected 1001", ctl_a); end
    @(negedge clk_i); ready = 1; branch = 1; #1;
    n_vec++; if (ctl_a !== 4'b1011) begin n_err++; $display("FAIL b2b_second_branch: got %b expected 1011", ctl_a); end
    @(negedge clk_i); branch = 0; #1;
    n_vec++; if (ctl_a !== 4'b1001) begin n_err++; $display("FAIL b2b_reload1: got %b expected 1001", ctl_a); end
    @(negedge clk_i); #1;
    n_vec++; if (ctl_a !== 4'b1001) begin n_err++; $display("FAIL b2b_reload2: got %b expected 1001", ctl_a); end
    @(negedge clk_i); #1;
    n_vec++; if (ctl_a !== 4'b1100) begin n_err++; $display("FAIL b2b_run: got %b expected 1100", ctl_a); end
    n_vec++; if (flcnt_a !== 16'd2 || stall_a !== 16'd0) begin
      n_err++; $display("FAIL b2b_counts: flush=%0d stall=%0d expected 2 0", flcnt_a, stall_a); end
  endtask

  task automatic test_imem_wait();
    do_reset();
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (ctl_a !== 4'b0001) begin n_err++; $display("FAIL imem_wait_c%0d: got %b expected 0001", i, ctl_a); end
      @(negedge clk_i);
    end
    ready = 1; #1;
    n_vec++; if (ctl_a !== 4'b1100) begin n_err++; $display("FAIL imem_ready_cycle: got %b expected 1100", ctl_a); end
    @(negedge clk_i); #1;
    n_vec++; if (dut.state_q !== RUN) begin n_err++; $display("FAIL imem_exit_state: got %0d expected %0d", dut.state_q, RUN); end
    n_vec++; if (stall_a !== 16'd3 || err_a !== 1'b0) begin
      n_err++; $display("FAIL imem_counts: stall=%0d err=%b expected 3 0", stall_a, err_a); end
  endtask

  task automatic test_timeout();
    do_reset();
    ready = 0;
    repeat (4) @(negedge clk_i);
    #1;
    n_vec++; if (err_a !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b expected 0", err_a); end
    @(negedge clk_i); #1;
    n_vec++; if (err_a !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b expected 1", err_a); end
    n_vec++; if (stall_a !== 16'd5) begin n_err++; $display("FAIL timeout_stalls: got %0d expected 5", stall_a); end
    ready = 1;
    repeat (3) @(negedge clk_i);
    #1;
    n_vec++; if (err_a !== 1'b1 || err_b !== 1'b0) begin
      n_err++; $display("FAIL timeout_sticky: a=%b b=%b expected 1 0", err_a, err_b); end
    do_reset(); #1;
    n_vec++; if (err_a !== 1'b0) begin n_err++; $display("FAIL timeout_cleared: got %b expected 0", err_a); end
  endtask

  task automatic test_saturate();
    do_reset();
    ready = 0;
    repeat (10) @(negedge clk_i);
    #1;
    n_vec++; if (stall_b !== 3'd7) begin n_err++; $display("FAIL sat_stall_b: got %0d expected 7", stall_b); end
    n_vec++; if (stall_a !== 16'd10) begin n_err++; $display("FAIL sat_stall_a: got %0d expected 10", stall_a); end
    ready = 1;
  endtask

  task automatic test_priority();
    do_reset();
    memread = 1; ex_rd = 5; id_rs1 = 5; branch = 1; ready = 0; #1;
    n_vec++; if (ctl_b !== 4'b1011) begin n_err++; $display("FAIL prio_ctl_b: got %b expected 1011", ctl_b); end
    n_vec++; if (ctl_a !== 4'b1011) begin n_err++; $display("FAIL prio_ctl_a: got %b expected 1011", ctl_a); end
    @(negedge clk_i); idle(); #1;
    n_vec++; if (dut0.state_q !== RUN) begin n_err++; $display("FAIL prio_state_b: got %0d expected %0d", dut0.state_q, RUN); end
    n_vec++; if (flcnt_b !== 3'd1 || stall_b !== 3'd0) begin
      n_err++; $display("FAIL prio_counts_b: flush=%0d stall=%0d expected 1 0", flcnt_b, stall_b); end
    n_vec++; if (ctl_a !== 4'b1001) begin n_err++; $display("FAIL prio_flush_a: got %b expected 1001", ctl_a); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_flush();
    test_back_to_back();
    test_imem_wait();
    test_timeout();
    test_saturate();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
